// File: rtl/chdr_pkt_len_enforcer.sv
// chdr_pkt_len_enforcer
// Sits on the DRAM FIFO output and makes the AXI-Stream framing agree with the
// CHDR header length: over-long packets are cut at the expected line count,
// runts are swallowed, short packets pass untouched. Framing errors are counted
// in saturating counters that the host can read and clear via the settings bus.
// The datapath is a zero-latency pass-through; only handshakes and tlast are
// steered by the small packet FSM.

module chdr_pkt_len_enforcer #(
   parameter logic [7:0] SR_BASE = 8'd0,
   parameter int         CNT_W   = 16
) (
   input  logic             bus_clk,
   input  logic             bus_rst,
   input  logic             set_stb,
   input  logic [7:0]       set_addr,
   input  logic [31:0]      set_data,
   input  logic [63:0]      i_tdata,
   input  logic             i_tlast,
   input  logic             i_tvalid,
   output logic             i_tready,
   output logic [63:0]      o_tdata,
   output logic             o_tlast,
   output logic             o_tvalid,
   input  logic             o_tready,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] short_cnt,
   output logic [CNT_W-1:0] long_cnt,
   output logic [CNT_W-1:0] runt_cnt
);

   typedef enum logic [1:0] {
      ST_HDR,
      ST_BODY,
      ST_DROP
   } state_t;

   state_t      state;
   logic        bypass;        // current packet was accepted with enable=0
   logic [12:0] line_cnt;      // lines of the current packet already forwarded
   logic [12:0] exp_lines_r;   // expected line count latched from the header
   logic        enable;
   logic        clr_pend;

   // Only bits [1:0] of the control word carry meaning.
   logic        ctrl_unused;
   assign ctrl_unused = ^set_data[31:2];

   // Header fields, valid whenever the FSM is waiting for a header.
   logic [15:0] hdr_len;
   logic        hdr_has_time;
   logic [16:0] len_p7;
   logic [12:0] hdr_exp_lines;
   logic        hdr_runt;
   logic        hdr_one_line;

   assign hdr_len       = i_tdata[47:32];
   assign hdr_has_time  = i_tdata[61];
   assign len_p7        = {1'b0, hdr_len} + 17'd7;
   assign hdr_exp_lines = len_p7[15:3];
   assign hdr_runt      = hdr_len < (hdr_has_time ? 16'd16 : 16'd8);
   assign hdr_one_line  = (hdr_exp_lines == 13'd1);

   logic [12:0] line_next;
   logic        body_at_end;

   assign line_next   = line_cnt + 13'd1;
   assign body_at_end = (line_next == exp_lines_r);

   assign o_tdata = i_tdata;

   // Handshake and tlast steering for the current state.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      o_tvalid = 1'b0;
      i_tready = 1'b0;
      o_tlast  = 1'b0;
      if (!bus_rst) begin
         case (state)
            ST_HDR: begin
               if (!enable) begin
                  o_tvalid = i_tvalid;
                  i_tready = o_tready;
                  o_tlast  = i_tlast;
               end else if (hdr_runt) begin
                  i_tready = 1'b1;
               end else begin
                  o_tvalid = i_tvalid;
                  i_tready = o_tready;
                  o_tlast  = i_tlast | hdr_one_line;
               end
            end
            ST_BODY: begin
               o_tvalid = i_tvalid;
               i_tready = o_tready;
               o_tlast  = i_tlast | (!bypass && body_at_end);
            end
            ST_DROP: begin
               i_tready = 1'b1;
            end
            default: ;
         endcase
      end
   end

   logic beat;
   assign beat = i_tvalid && i_tready;

   logic hdr_check;
   logic body_check;
   assign hdr_check  = beat && (state == ST_HDR) && enable && !hdr_runt;
   assign body_check = beat && (state == ST_BODY) && !bypass;

   logic pkt_inc, runt_inc, long_inc, short_inc;
   assign pkt_inc   = beat && (state == ST_HDR) && (!enable || !hdr_runt);
   assign runt_inc  = beat && (state == ST_HDR) && enable && hdr_runt;
   assign long_inc  = (hdr_check && hdr_one_line && !i_tlast) ||
                      (body_check && body_at_end && !i_tlast);
   assign short_inc = (hdr_check && !hdr_one_line && i_tlast) ||
                      (body_check && !body_at_end && i_tlast);

   // Packet FSM: advances only on accepted input beats.
   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         state       <= ST_HDR;
         bypass      <= 1'b0;
         line_cnt    <= 13'd0;
         exp_lines_r <= 13'd0;
      end else if (beat) begin
         // NOTE: non-blocking assignments keep every register reading pre-edge values.
         case (state)
            ST_HDR: begin
               if (!enable) begin
                  bypass <= 1'b1;
                  if (!i_tlast) state <= ST_BODY;
               end else if (hdr_runt) begin
                  if (!i_tlast) state <= ST_DROP;
               end else begin
                  bypass      <= 1'b0;
                  line_cnt    <= 13'd1;
                  exp_lines_r <= hdr_exp_lines;
                  if (hdr_one_line) begin
                     if (!i_tlast) state <= ST_DROP;
                  end else if (!i_tlast) begin
                     state <= ST_BODY;
                  end
               end
            end
            ST_BODY: begin
               line_cnt <= line_next;
               if (bypass) begin
                  if (i_tlast) state <= ST_HDR;
               end else if (body_at_end) begin
                  state <= i_tlast ? ST_HDR : ST_DROP;
               end else if (i_tlast) begin
                  state <= ST_HDR;
               end
            end
            ST_DROP: begin
               if (i_tlast) state <= ST_HDR;
            end
            default: state <= ST_HDR;
         endcase
      end
   end

   // Control register: enable plus a self-clearing counter-clear request.
   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         enable   <= 1'b1;
         clr_pend <= 1'b0;
      end else begin
         clr_pend <= set_stb && (set_addr == SR_BASE) && set_data[1];
         if (set_stb && (set_addr == SR_BASE)) enable <= set_data[0];
      end
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Saturating counters; a pending clear overrides any increment.
   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         pkt_cnt   <= '0;
         short_cnt <= '0;
         long_cnt  <= '0;
         runt_cnt  <= '0;
      end else if (clr_pend) begin
         pkt_cnt   <= '0;
         short_cnt <= '0;
         long_cnt  <= '0;
         runt_cnt  <= '0;
      end else begin
         if (pkt_inc)   pkt_cnt   <= sat_inc(pkt_cnt);
         if (short_inc) short_cnt <= sat_inc(short_cnt);
         if (long_inc)  long_cnt  <= sat_inc(long_cnt);
         if (runt_inc)  runt_cnt  <= sat_inc(runt_cnt);
      end
   end

endmodule
